// File: rtl/mvm_epi_pkg.sv
// Shared types and helpers for the post-MVM epilogue: FSM states, lane slicing
// and the internal arithmetic widths used by the rounding and saturation steps.
package mvm_epi_pkg;

  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

  // BN result (before residual) and residual-stage working widths
  localparam int INT_W = 64;
  localparam int RES_W = 80;

  function automatic int lane_lo(input int lane, input int w);
    return lane * w;
  endfunction

endpackage

// File: rtl/bn_lane_pipe.sv
// One output lane of the epilogue: BN multiply, bias/round, residual, ReLU and
// saturation in three register stages that all advance on a shared enable.
module bn_lane_pipe
  import mvm_epi_pkg::*;
#(
  parameter int ACC_DW = 32,
  parameter int BN_DW  = 16,
  parameter int DAT_DW = 16
) (
  input  logic              clk,
  input  logic              en,
  input  logic [ACC_DW-1:0] acc,
  input  logic [BN_DW-1:0]  w,
  input  logic [BN_DW-1:0]  bias,
  input  logic [DAT_DW-1:0] res,
  input  logic [4:0]        bias_shift,
  input  logic [5:0]        out_shift,
  input  logic              res_en,
  input  logic              res_mode,
  input  logic [4:0]        res_shift,
  input  logic              relu_en,
  output logic [DAT_DW-1:0] dat
);

  localparam int PW = ACC_DW + BN_DW;

  logic signed [PW-1:0]     prod_p0;
  logic signed [BN_DW-1:0]  bias_p0;
  logic signed [DAT_DW-1:0] res_p0, res_p1;
  logic signed [INT_W-1:0]  v_p1;
  logic signed [DAT_DW-1:0] dat_p2;
  logic signed [INT_W-1:0]  prod_x, bias_x;

  function automatic logic signed [INT_W-1:0] round_shr(input logic signed [INT_W-1:0] x,
                                                        input logic [5:0] sh);
    logic signed [INT_W-1:0] rnd;
    rnd = (sh == 6'd0) ? '0 : (INT_W'(1) <<< (sh - 6'd1));
    return (x + rnd) >>> sh;
  endfunction

  function automatic logic signed [RES_W-1:0] res_act(input logic signed [INT_W-1:0] v,
                                                      input logic signed [DAT_DW-1:0] r,
                                                      input logic ren, input logic rmode,
                                                      input logic [4:0] rsh, input logic relu);
    logic signed [RES_W-1:0] vx, rx, t;
    vx = $signed({{(RES_W-INT_W){v[INT_W-1]}}, v});
    rx = $signed({{(RES_W-DAT_DW){r[DAT_DW-1]}}, r});
    t  = vx;
    if (ren) t = rmode ? ((vx * rx) >>> rsh) : (vx + (rx <<< rsh));
    if (relu && t[RES_W-1]) t = '0;
    return t;
  endfunction

  function automatic logic signed [DAT_DW-1:0] sat(input logic signed [RES_W-1:0] x);
    logic signed [RES_W-1:0] hi, lo;
    hi = {{(RES_W-DAT_DW+1){1'b0}}, {(DAT_DW-1){1'b1}}};
    lo = ~hi;
    if (x > hi) return {1'b0, {(DAT_DW-1){1'b1}}};
    else if (x < lo) return {1'b1, {(DAT_DW-1){1'b0}}};
    else return x[DAT_DW-1:0];
  endfunction

  assign prod_x = $signed({{(INT_W-PW){prod_p0[PW-1]}}, prod_p0});
  assign bias_x = $signed({{(INT_W-BN_DW){bias_p0[BN_DW-1]}}, bias_p0}) <<< bias_shift;

  always_ff @(posedge clk) begin
    if (en) begin
      // stage p0: BN multiply
      prod_p0 <= $signed({{BN_DW{acc[ACC_DW-1]}}, acc}) * $signed({{ACC_DW{w[BN_DW-1]}}, w});
      bias_p0 <= bias;
      res_p0  <= res;
      // stage p1: bias add and rounding shift
      v_p1    <= round_shr(prod_x + bias_x, out_shift);
      res_p1  <= res_p0;
      // stage p2: residual, ReLU, saturation
      dat_p2  <= sat(res_act(v_p1, res_p1, res_en, res_mode, res_shift, relu_en));
    end
  end

  assign dat = dat_p2;

endmodule

// File: rtl/mvm_bn_res_act.sv
// Post-MVM epilogue top: BN parameter buffer, run FSM with pixel/group counters,
// and TOUT arithmetic lanes behind a single valid/ready pipeline.
module mvm_bn_res_act
  import mvm_epi_pkg::*;
#(
  parameter int TOUT          = 32,
  parameter int ACC_DW        = 32,
  parameter int BN_DW         = 16,
  parameter int DAT_DW        = 16,
  parameter int MAX_CH_GROUPS = 64,
  parameter int PIX_W         = 20
) (
  input  logic                               clk,
  input  logic                               rst_n,
  input  logic                               prm_we,
  input  logic [$clog2(MAX_CH_GROUPS)-1:0]   prm_waddr,
  input  logic [TOUT*2*BN_DW-1:0]            prm_wdata,
  input  logic                               start,
  input  logic [PIX_W-1:0]                   cfg_pixels,
  input  logic [$clog2(MAX_CH_GROUPS):0]     cfg_ch_groups,
  input  logic [4:0]                         cfg_bias_shift,
  input  logic [5:0]                         cfg_out_shift,
  input  logic                               cfg_res_en,
  input  logic                               cfg_res_mode,
  input  logic [4:0]                         cfg_res_shift,
  input  logic                               cfg_relu_en,
  input  logic                               in_valid,
  output logic                               in_ready,
  input  logic [TOUT*ACC_DW-1:0]             in_acc,
  input  logic [TOUT*DAT_DW-1:0]             in_res,
  output logic                               out_valid,
  input  logic                               out_ready,
  output logic [TOUT*DAT_DW-1:0]             out_dat,
  output logic                               busy,
  output logic                               done
);

  localparam int GA_W  = $clog2(MAX_CH_GROUPS);
  localparam int GC_W  = GA_W + 1;
  localparam int PRM_W = TOUT * 2 * BN_DW;

  state_t             state;
  logic [PIX_W-1:0]   pix, pixels_q;
  logic [GC_W-1:0]    grp, groups_q;
  logic [4:0]         bias_shift_q, res_shift_q;
  logic [5:0]         out_shift_q;
  logic               res_en_q, res_mode_q, relu_en_q;
  logic               vld_p0, vld_p1, vld_p2;
  logic               en, accept, pix_last, grp_last;
  logic [PRM_W-1:0]   prm_mem [MAX_CH_GROUPS];
  logic [PRM_W-1:0]   prm_rd;
  logic [TOUT*DAT_DW-1:0] dat_all;

  assign en        = !vld_p2 || out_ready;
  assign in_ready  = en && (state == RUN);
  assign accept    = in_valid && in_ready;
  assign pix_last  = (pix == pixels_q - PIX_W'(1));
  assign grp_last  = (grp == groups_q - GC_W'(1));
  assign out_valid = vld_p2;
  // Data registers are not reset, so the bus is masked to stay 0 when idle
  assign out_dat   = vld_p2 ? dat_all : '0;

  always_ff @(posedge clk) begin
    if (prm_we && state == IDLE) prm_mem[prm_waddr] <= prm_wdata;
  end

  assign prm_rd = prm_mem[grp[GA_W-1:0]];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      pix          <= '0;
      grp          <= '0;
      pixels_q     <= '0;
      groups_q     <= '0;
      bias_shift_q <= '0;
      out_shift_q  <= '0;
      res_shift_q  <= '0;
      res_en_q     <= 1'b0;
      res_mode_q   <= 1'b0;
      relu_en_q    <= 1'b0;
      busy         <= 1'b0;
      done         <= 1'b0;
    end else begin
      done <= 1'b0;
      unique case (state)
        IDLE: begin
          busy <= 1'b0;
          if (start) begin
            pixels_q     <= cfg_pixels;
            groups_q     <= cfg_ch_groups;
            bias_shift_q <= cfg_bias_shift;
            out_shift_q  <= cfg_out_shift;
            res_shift_q  <= cfg_res_shift;
            res_en_q     <= cfg_res_en;
            res_mode_q   <= cfg_res_mode;
            relu_en_q    <= cfg_relu_en;
            pix          <= '0;
            grp          <= '0;
            busy         <= 1'b1;
            // An empty surface finishes immediately without entering RUN
            if (cfg_pixels == '0 || cfg_ch_groups == '0) done <= 1'b1;
            else state <= RUN;
          end
        end
        RUN: begin
          if (accept) begin
            if (pix_last) begin
              pix <= '0;
              if (grp_last) state <= DRAIN;
              else grp <= grp + GC_W'(1);
            end else begin
              pix <= pix + PIX_W'(1);
            end
          end
        end
        DRAIN: begin
          // The last beat is leaving when nothing remains behind it
          if (vld_p2 && out_ready && !vld_p0 && !vld_p1) begin
            state <= IDLE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_p0 <= 1'b0;
      vld_p1 <= 1'b0;
      vld_p2 <= 1'b0;
    end else if (en) begin
      vld_p0 <= accept;
      vld_p1 <= vld_p0;
      vld_p2 <= vld_p1;
    end
  end

  for (genvar i = 0; i < TOUT; i++) begin : g_lane
    bn_lane_pipe #(
      .ACC_DW(ACC_DW),
      .BN_DW (BN_DW),
      .DAT_DW(DAT_DW)
    ) u_lane (
      .clk       (clk),
      .en        (en),
      .acc       (in_acc[lane_lo(i, ACC_DW) +: ACC_DW]),
      .w         (prm_rd[lane_lo(i, 2*BN_DW) +: BN_DW]),
      .bias      (prm_rd[lane_lo(i, 2*BN_DW) + BN_DW +: BN_DW]),
      .res       (in_res[lane_lo(i, DAT_DW) +: DAT_DW]),
      .bias_shift(bias_shift_q),
      .out_shift (out_shift_q),
      .res_en    (res_en_q),
      .res_mode  (res_mode_q),
      .res_shift (res_shift_q),
      .relu_en   (relu_en_q),
      .dat       (dat_all[lane_lo(i, DAT_DW) +: DAT_DW])
    );
  end

endmodule
